ddr_uart_burst_ctrl: RTL and testbench
======================================

Name: ddr_uart_burst_ctrl

Overview:
- Frame controller between the UART byte stream and the DDR3 controller user (app) interface.
- Parses command frames from UART RX bytes and packs 32 write-data bytes into one 256-bit burst.
- Issues write or read commands to DDR3 with full app-interface handshakes.
- Serializes 256-bit read data back to UART TX one byte at a time.

Parameters:
ADDR_W, 28, app_addr width; the low ADDR_W bits of the received 32-bit address are used
DATA_W, 256, burst width; fixed at 32 bytes, and other values are unsupported
TIMEOUT_CYC, 100000, idle clk cycles allowed between RX bytes inside a frame before the frame is abandoned

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
init_calib_complete  in  1  DDR3 calibration done; no frame is accepted while low
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data is valid
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  UART TX accepts the byte when tx_valid and tx_ready are both high
app_addr  out  ADDR_W  DDR3 command address
app_cmd  out  3  3'b000 write, 3'b001 read
app_en  out  1  command request; held until app_rdy
app_rdy  in  1  controller accepts the command this cycle
app_wdf_data  out  DATA_W  write burst
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  last beat; always equal to app_wdf_wren (single-beat burst)
app_wdf_rdy  in  1  write FIFO accepts the data this cycle
app_rd_data  in  DATA_W  read burst
app_rd_data_valid  in  1  read burst valid (one cycle)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame completion
frame_err  out  1  one-cycle pulse on a bad command byte or a timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0, including app_addr, app_wdf_data and tx_data. Byte counter, timeout counter and accept flags are cleared.
- Reset mid-operation aborts immediately. Outstanding app requests are dropped; a read response arriving after reset is ignored.
- Frame format: CMD byte, then 4 address bytes (MSB first), then 32 data bytes (write only).
  - CMD 0x57 ('W') = write; CMD 0x52 ('R') = read.
- Data byte packing: byte k (k=0..31) goes to bits [255-8k -: 8]. Word0 therefore occupies the MSBs, matching the 8x32 word assembly order.
- IDLE:
  - If rx_valid and init_calib_complete: 0x57 or 0x52 → ADDR with the command latched.
  - Any other byte → frame_err pulse, stay in IDLE.
  - rx_valid while init_calib_complete=0: byte dropped silently.
- ADDR: shift in 4 bytes, then → WDATA (write) or RCMD (read).
- WDATA: capture 32 bytes into the burst register; after byte 31 → WCMD.
- Timeout (ADDR and WDATA only):
  - The counter resets on every rx_valid.
  - When it reaches TIMEOUT_CYC: frame_err pulse, → IDLE, partial data discarded.
- WCMD:
  - app_en=1 and app_cmd=000 until the cycle app_rdy=1.
  - app_wdf_wren=app_wdf_end=1 until the cycle app_wdf_rdy=1.
  - The two handshakes are independent: either may complete first or both in the same cycle. Each side deasserts the cycle after its accept.
  - When both have been accepted: done pulse, → IDLE.
- RCMD: app_en=1 and app_cmd=001 until app_rdy, then → RWAIT.
- RWAIT: on app_rd_data_valid, capture app_rd_data → TXD.
- app_rd_data_valid outside RWAIT is ignored.
- TXD:
  - Bytes are sent MSB first ([255:248] first). tx_valid stays high and tx_data stays stable until tx_ready.
  - The next byte is presented the cycle after accept; each byte therefore takes at least 2 cycles.
  - After byte 31 is accepted: done pulse, → IDLE.
- app_addr is latched at ADDR exit and stays stable throughout WCMD and RCMD.
- rx_valid in WCMD, RCMD, RWAIT or TXD: byte dropped. No state change and no error pulse.
- No timeout applies in WCMD, RCMD, RWAIT or TXD; the block waits indefinitely on the DDR3 and TX handshakes.

Test Plan:
- Write frame: 0x57, 00 00 01 00, bytes 0x00..0x1F, with app_rdy=app_wdf_rdy=1 → app_addr=0x100, app_cmd=0, app_wdf_data[255:248]=0x00 and [7:0]=0x1F, single wren/end cycle, done pulse, busy falls.
- Backpressure: as above but app_rdy low 5 cycles and app_wdf_rdy low 9 cycles → app_en held 6 cycles, wren held 10 cycles, done only after the later accept, data stable throughout.
- Read frame: 0x52, 00 00 01 00; app_rd_data_valid 3 cycles after accept with data 0x0102...20; tx_ready toggling → 32 TX bytes 0x01..0x20 in order, tx_data stable while stalled, done after byte 32.
- Bad command 0xAA → frame_err pulse, busy stays 0. Command 0x57 with init_calib_complete=0 → ignored.
- Timeout: 0x57 plus 2 address bytes, then silence for TIMEOUT_CYC cycles (bench sets TIMEOUT_CYC=50) → frame_err pulse, IDLE. A following full write frame completes correctly.
- Reset mid-write: assert rst while app_en is waiting on app_rdy=0 → all outputs 0 asynchronously. After release, a new read frame completes normally.

Source files
------------

// File: rtl/ddr_uart_burst_ctrl.sv
// Frame controller between a UART byte stream and the DDR3 app interface:
// parses W/R command frames, runs the app handshakes, streams read bursts to TX.
module ddr_uart_burst_ctrl #(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WCMD  = 3'd3;
  localparam logic [2:0] S_RCMD  = 3'd4;
  localparam logic [2:0] S_RWAIT = 3'd5;
  localparam logic [2:0] S_TXD   = 3'd6;

  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdbuf_q, rdbuf_d;
  logic              en_ok_q, en_ok_d;
  logic              wdf_ok_q, wdf_ok_d;
  logic              gap_q, gap_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  assign busy         = (state_q != S_IDLE);
  assign app_en       = (state_q == S_RCMD) || ((state_q == S_WCMD) && !en_ok_q);
  assign app_cmd      = (state_q == S_RCMD) ? 3'b001 : 3'b000;
  assign app_wdf_wren = (state_q == S_WCMD) && !wdf_ok_q;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = wdata_q;
  assign app_addr     = app_addr_q;
  assign tx_valid     = (state_q == S_TXD) && !gap_q;
  assign tx_data      = rdbuf_q[DATA_W-1 -: 8];
  assign done         = done_q;
  assign frame_err    = err_q;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    app_addr_d = app_addr_q;
    wdata_d    = wdata_q;
    rdbuf_d    = rdbuf_q;
    en_ok_d    = en_ok_q;
    wdf_ok_d   = wdf_ok_q;
    gap_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && init_calib_complete) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            state_d = S_ADDR;
            is_wr_d = (rx_data == 8'h57);
            cnt_d   = '0;
            wdata_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR, S_WDATA: begin
        if (rx_valid) begin
          cnt_d = cnt_q + 5'd1;
          if (state_q == S_ADDR) begin
            // Shifting straight into the output register: the value is only
            // consumed after the fourth byte, so it is final at ADDR exit.
            app_addr_d = ADDR_W'({app_addr_q, rx_data});
            if (cnt_q == 5'd3) begin
              cnt_d   = '0;
              state_d = is_wr_q ? S_WDATA : S_RCMD;
            end
          end else begin
            wdata_d = {wdata_q[DATA_W-9:0], rx_data};
            if (cnt_q == 5'd31) begin
              cnt_d    = '0;
              en_ok_d  = 1'b0;
              wdf_ok_d = 1'b0;
              state_d  = S_WCMD;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WCMD: begin
        en_ok_d  = en_ok_q || app_rdy;
        wdf_ok_d = wdf_ok_q || app_wdf_rdy;
        if (en_ok_d && wdf_ok_d) begin
          en_ok_d  = 1'b0;
          wdf_ok_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RCMD: begin
        if (app_rdy) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (app_rd_data_valid) begin
          rdbuf_d = app_rd_data;
          cnt_d   = '0;
          state_d = S_TXD;
        end
      end
      S_TXD: begin
        // One idle cycle after each accepted byte while the next one shifts up.
        if (!gap_q && tx_ready) begin
          rdbuf_d = {rdbuf_q[DATA_W-9:0], 8'h00};
          cnt_d   = cnt_q + 5'd1;
          gap_d   = 1'b1;
          if (cnt_q == 5'd31) begin
            gap_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      app_addr_q <= '0;
      wdata_q    <= '0;
      rdbuf_q    <= '0;
      en_ok_q    <= 1'b0;
      wdf_ok_q   <= 1'b0;
      gap_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      app_addr_q <= app_addr_d;
      wdata_q    <= wdata_d;
      rdbuf_q    <= rdbuf_d;
      en_ok_q    <= en_ok_d;
      wdf_ok_q   <= wdf_ok_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr_uart_burst_ctrl.sv
// Directed bench for ddr_uart_burst_ctrl: frame-level model plus a per-cycle
// compare process watching the app and TX handshakes.
module tb_ddr_uart_burst_ctrl;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int TMO    = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              init_calib_complete = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy = 1'b0;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy = 1'b0;
  logic [DATA_W-1:0] app_rd_data = '0;
  logic              app_rd_data_valid = 1'b0;
  logic              busy;
  logic              done;
  logic              frame_err;

  always #5 clk = ~clk;

  ddr_uart_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Frame-level model: what the current frame must present on the app interface and TX.
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [2:0]        exp_cmd = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic [7:0]        exp_tx[$];
  logic [7:0]        got_tx[$];

  // Observations accumulated by the compare process.
  int cyc = 0;
  int en_cyc_n = 0, wr_cyc_n = 0, en_acc_n = 0, wdf_acc_n = 0;
  int done_n = 0, err_n = 0, tx_acc_n = 0;
  int en_acc_cyc = 0, wdf_acc_cyc = 0, done_cyc = 0, tx_acc_cyc = 0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic [DATA_W-1:0] cap_wdata = '0;

  initial begin
    logic p_en_wait, p_wr_wait, p_tx_wait, p_tx_acc;
    logic [7:0] p_tx_data;
    logic [7:0] w;
    p_en_wait = 0; p_wr_wait = 0; p_tx_wait = 0; p_tx_acc = 0; p_tx_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_en_wait = 0; p_wr_wait = 0; p_tx_wait = 0; p_tx_acc = 0;
      end else begin
        cyc++;
        chk("wdf_end_eq_wren", app_wdf_end, app_wdf_wren);
        if (app_en) begin
          chk("app_addr", app_addr, exp_addr);
          chk("app_cmd", app_cmd, exp_cmd);
          chk("busy_during_cmd", busy, 1'b1);
          cap_addr = app_addr;
          en_cyc_n++;
        end
        if (app_wdf_wren) begin
          chk("wdf_data", app_wdf_data, exp_wdata);
          cap_wdata = app_wdf_data;
          wr_cyc_n++;
        end
        if (p_en_wait) chk("app_en_held", app_en, 1'b1);
        if (p_wr_wait) chk("wren_held", app_wdf_wren, 1'b1);
        if (p_tx_wait) begin
          chk("tx_valid_held", tx_valid, 1'b1);
          chk("tx_data_stable", tx_data, p_tx_data);
        end
        if (p_tx_acc) chk("tx_two_cycle_min", tx_valid && tx_ready, 1'b0);
        if (done || frame_err) chk("busy_low_at_end", busy, 1'b0);
        if (done) chk("done_err_exclusive", frame_err, 1'b0);
        if (app_en && app_rdy) begin en_acc_n++; en_acc_cyc = cyc; end
        if (app_wdf_wren && app_wdf_rdy) begin wdf_acc_n++; wdf_acc_cyc = cyc; end
        if (tx_valid && tx_ready) begin
          tx_acc_n++;
          tx_acc_cyc = cyc;
          got_tx.push_back(tx_data);
          chk("tx_byte_expected", exp_tx.size() != 0, 1'b1);
          if (exp_tx.size() != 0) begin
            w = exp_tx.pop_front();
            chk("tx_byte", tx_data, w);
          end
        end
        if (done) begin done_n++; done_cyc = cyc; end
        if (frame_err) begin err_n++; end
        p_en_wait = app_en && !app_rdy;
        p_wr_wait = app_wdf_wren && !app_wdf_rdy;
        p_tx_wait = tx_valid && !tx_ready;
        p_tx_acc  = tx_valid && tx_ready;
        p_tx_data = tx_data;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] base);
    exp_addr = addr[ADDR_W-1:0];
    exp_cmd  = (cmd == 8'h52) ? 3'b001 : 3'b000;
    for (int k = 0; k < 32; k++) exp_wdata[255-8*k -: 8] = base + 8'(k);
    send(cmd);
    for (int i = 3; i >= 0; i--) send(addr[8*i +: 8]);
    if (cmd == 8'h57) for (int k = 0; k < 32; k++) send(base + 8'(k));
  endtask

  task automatic wait_done(input int snap, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done_n != snap) break;
    end
    chk("done_pulse_count", done_n - snap, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_app_en"}, app_en, 0);
    chk({tag, "_wren"}, app_wdf_wren, 0);
    chk({tag, "_wdf_end"}, app_wdf_end, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_app_addr"}, app_addr, 0);
    chk({tag, "_app_cmd"}, app_cmd, 0);
    chk({tag, "_wdf_data"}, app_wdf_data, 0);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] base, input bit inject);
    int s_done, s_err, s_tx;
    bit found;
    logic [DATA_W-1:0] rd;
    app_rdy = 1'b1;
    for (int k = 0; k < 32; k++) begin
      rd[255-8*k -: 8] = base + 8'(k);
      exp_tx.push_back(base + 8'(k));
    end
    got_tx.delete();
    s_done = done_n; s_err = err_n; s_tx = tx_acc_n;
    send_frame(8'h52, addr, 8'h00);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (app_en && app_rdy) begin found = 1; break; end
    end
    chk("rd_cmd_issued", found, 1'b1);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2 app_rd_data = rd; app_rd_data_valid = 1'b1;
    @(posedge clk); #2 app_rd_data_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (done_n != s_done) break;
      @(posedge clk); #2;
      tx_ready = ((i % 3) != 1);
      if (inject && i == 6) begin rx_data = 8'h57; rx_valid = 1'b1; end
      else rx_valid = 1'b0;
    end
    tx_ready = 1'b0; rx_valid = 1'b0;
    chk("rd_done_count", done_n - s_done, 1);
    chk("rd_tx_count", tx_acc_n - s_tx, 32);
    chk("rd_tx_left", exp_tx.size(), 0);
    chk("rd_done_after_last", done_cyc, tx_acc_cyc + 1);
    chk("rd_no_err", err_n - s_err, 0);
    exp_tx.delete();
  endtask

  initial begin
    int s_done, s_err, s_en, s_wr, k;
    bit found;

    // Reset state
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1; init_calib_complete = 1'b1;
    @(negedge clk) check_all_zero("post_reset");

    // Write frame, no backpressure
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    s_done = done_n; s_err = err_n; s_en = en_cyc_n; s_wr = wr_cyc_n;
    send_frame(8'h57, 32'h0000_0100, 8'h00);
    wait_done(s_done, 50);
    chk("w1_en_cycles", en_cyc_n - s_en, 1);
    chk("w1_wren_cycles", wr_cyc_n - s_wr, 1);
    chk("w1_no_err", err_n - s_err, 0);
    chk("w1_addr_lit", cap_addr, 28'h100);
    chk("w1_data_msb_lit", cap_wdata[255:248], 8'h00);
    chk("w1_data_lsb_lit", cap_wdata[7:0], 8'h1F);
    chk("w1_busy_after", busy, 1'b0);

    // Write frame with independent backpressure on both handshakes
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    s_done = done_n; s_en = en_cyc_n; s_wr = wr_cyc_n;
    send_frame(8'h57, 32'h0000_0200, 8'h40);
    repeat (5) @(posedge clk);
    #2 app_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #2 app_wdf_rdy = 1'b1;
    wait_done(s_done, 50);
    chk("bp_en_cycles", en_cyc_n - s_en, 6);
    chk("bp_wren_cycles", wr_cyc_n - s_wr, 10);
    chk("bp_en_first", en_acc_cyc < wdf_acc_cyc, 1'b1);
    chk("bp_done_after_later", done_cyc, wdf_acc_cyc + 1);
    chk("bp_data_msb_lit", cap_wdata[255:248], 8'h40);

    // Read with a stray read response in IDLE and a dropped RX byte during TX
    @(posedge clk); #2 app_rd_data = '1; app_rd_data_valid = 1'b1;
    @(posedge clk); #2 app_rd_data_valid = 1'b0;
    @(negedge clk) chk("stray_rd_busy", busy, 1'b0);
    run_read(32'h0000_0100, 8'h01, 1'b1);
    chk("rd_got_32", got_tx.size(), 32);
    if (got_tx.size() == 32) begin
      chk("rd_first_lit", got_tx[0], 8'h01);
      chk("rd_last_lit", got_tx[31], 8'h20);
    end
    @(negedge clk) chk("rd_injected_dropped", busy, 1'b0);

    // Bad command byte, then a command while calibration is incomplete
    s_err = err_n;
    send(8'hAA);
    repeat (3) @(negedge clk);
    chk("bad_cmd_err", err_n - s_err, 1);
    chk("bad_cmd_busy", busy, 1'b0);
    init_calib_complete = 1'b0;
    s_err = err_n;
    send(8'h57);
    repeat (3) @(negedge clk);
    chk("nocal_busy", busy, 1'b0);
    chk("nocal_err", err_n - s_err, 0);
    init_calib_complete = 1'b1;

    // Timeout mid-address, then a full write frame
    s_err = err_n;
    send(8'h57); send(8'h00); send(8'h00);
    k = 0;
    for (int i = 1; i <= TMO + 5; i++) begin
      @(negedge clk);
      if (frame_err) begin k = i; break; end
    end
    chk("tmo_window", (k >= TMO + 1) && (k <= TMO + 2), 1'b1);
    chk("tmo_err_count", err_n - s_err, 1);
    chk("tmo_idle", busy, 1'b0);
    s_done = done_n; s_err = err_n;
    send_frame(8'h57, 32'hFABC_DEF1, 8'hA0);
    wait_done(s_done, 50);
    chk("tmo_w_addr_lit", cap_addr, 28'hABCDEF1);
    chk("tmo_w_lsb_lit", cap_wdata[7:0], 8'hBF);
    chk("tmo_w_no_err", err_n - s_err, 0);

    // Reset while app_en waits on app_rdy
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    send_frame(8'h57, 32'h0000_0300, 8'h80);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (app_en) begin found = 1; break; end
    end
    chk("rst_en_waiting", found, 1'b1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 app_rd_data = '1; app_rd_data_valid = 1'b1;
    @(posedge clk); #2 app_rd_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_late_rd_busy", busy, 1'b0);
    chk("rst_late_rd_tx", tx_valid, 1'b0);
    run_read(32'h1234_5678, 8'h60, 1'b0);
    chk("rst_rd_addr_lit", cap_addr, 28'h2345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
